// File: rtl/next_level_arbiter_pkg.sv
// Shared types for the next-level port arbiter: requester op codes and FSM states.
package next_level_arbiter_pkg;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RESET      = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Width of the WAIT-state timeout timer.
  localparam int TIMER_W = 8;

  // Width of the per-requester completed-transaction counters.
  localparam int CNT_W = 32;

endpackage

// File: rtl/next_level_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: scans req starting at ptr and returns
// a one-hot grant plus its binary index. 'any' flags that some request won.
module next_level_arbiter_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int             pos;
  logic [IDW-1:0] sel;

  // First requesting slot at or after ptr (mod NREQ) wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      sel = IDW'(pos);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/next_level_arbiter.sv
// Shares one next-level cache port among NREQ requesters: round-robin grant
// with RESET-op priority, a single outstanding transaction, a WAIT timeout
// that completes with an error, and saturating per-requester completion counts.
module next_level_arbiter
  import next_level_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int LADDRBITS = 26,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  op_t                  req_op    [NREQ],
  input  logic [LADDRBITS-1:0] req_addr  [NREQ],
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_error,
  output logic                 nx_valid,
  output op_t                  nx_op,
  output logic [LADDRBITS-1:0] nx_addr,
  input  logic                 nx_ready,
  input  logic                 nx_done,
  output logic [CNT_W-1:0]     grant_cnt [NREQ]
);

  localparam int                 IDW  = $clog2(NREQ);
  localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(TIMEOUT);
  localparam logic [IDW-1:0]     LAST = IDW'(NREQ - 1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  arb_state_t           state, state_next;
  logic [IDW-1:0]       rr_ptr, id_q;
  op_t                  op_q;
  logic [LADDRBITS-1:0] addr_q;
  logic [TIMER_W-1:0]   timer;
  logic                 err_q;

  logic [NREQ-1:0]      eligible, urgent, pick_req, pick_grant;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_any;

  // Eligible requesters; RESET ops form a higher-priority subset that wins outright.
  always_comb begin
    eligible = '0;
    urgent   = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (req_op[i] != NOP);
      urgent[i]   = req_valid[i] && (req_op[i] == RESET);
    end
    pick_req = (|urgent) ? urgent : eligible;
  end

  next_level_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state decode and Moore-style outputs for the transaction sequencer.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_error  = 1'b0;
    nx_valid   = 1'b0;
    nx_op      = NOP;
    nx_addr    = '0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready  = pick_grant;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        nx_valid = 1'b1;
        nx_op    = op_q;
        nx_addr  = addr_q;
        // A done that arrives with the handshake skips WAIT entirely.
        if (nx_ready) state_next = nx_done ? RESP : WAIT;
      end
      WAIT: begin
        if (nx_done || (timer == TMAX)) state_next = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        rsp_error       = err_q;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Latched request, timeout timer, round-robin pointer and completion counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      id_q   <= '0;
      op_q   <= NOP;
      addr_q <= '0;
      timer  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            id_q   <= pick_idx;
            op_q   <= req_op[pick_idx];
            addr_q <= req_addr[pick_idx];
            err_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (nx_done)              err_q <= 1'b0;
          else if (timer == TMAX)   err_q <= 1'b1;
          else                      timer <= timer + TIMER_W'(1);
        end
        RESP: begin
          timer           <= '0;
          rr_ptr          <= (id_q == LAST) ? '0 : id_q + IDW'(1);
          grant_cnt[id_q] <= sat_inc(grant_cnt[id_q]);
        end
        default: ;
      endcase
    end
  end

  // A pending request must keep valid/op/addr stable until it is accepted.
  for (genvar g = 0; g < NREQ; g++) begin : g_hold
    assert property (@(posedge clock) disable iff (reset)
      (req_valid[g] && (req_op[g] != NOP) && !req_ready[g]) |=>
      (req_valid[g] && (req_op[g] == $past(req_op[g])) && (req_addr[g] == $past(req_addr[g]))));
  end

endmodule

// File: tb/tb_next_level_arbiter.sv
// Scoreboard bench for next_level_arbiter: directed stimulus pushes expected
// next-level issues, responses and spot values into queues; a monitor process
// pops and compares them whenever the DUT presents the corresponding output.
module tb_next_level_arbiter;
  import next_level_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int LB   = 26;
  localparam int TO   = 255;

  logic             clock;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  op_t              req_op   [NREQ];
  logic [LB-1:0]    req_addr [NREQ];
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  rsp_valid;
  logic             rsp_error;
  logic             nx_valid;
  op_t              nx_op;
  logic [LB-1:0]    nx_addr;
  logic             nx_ready;
  logic             nx_done;
  logic [31:0]      grant_cnt [NREQ];

  next_level_arbiter #(
    .NREQ      (NREQ),
    .LADDRBITS (LB),
    .TIMEOUT   (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_error (rsp_error),
    .nx_valid  (nx_valid),
    .nx_op     (nx_op),
    .nx_addr   (nx_addr),
    .nx_ready  (nx_ready),
    .nx_done   (nx_done),
    .grant_cnt (grant_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct { int id; logic err; } rsp_t;
  typedef struct { op_t op; logic [LB-1:0] addr; } nxe_t;
  typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

  rsp_t rsp_q [$];
  nxe_t nx_q  [$];
  chk_t chk_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  bit end_flag = 1'b0;

  // Per-cycle snapshot taken at the falling edge by step().
  logic            s_nx_valid;
  op_t             s_nx_op;
  logic [LB-1:0]   s_nx_addr;
  logic [NREQ-1:0] s_rsp_valid;
  logic            s_rsp_error;
  logic [NREQ-1:0] s_req_ready;
  int              rem [NREQ];

  task automatic exp_nx(input op_t op, input logic [LB-1:0] addr);
    nxe_t e;
    e.op = op; e.addr = addr;
    nx_q.push_back(e);
  endtask

  task automatic exp_rsp(input int id, input logic err);
    rsp_t e;
    e.id = id; e.err = err;
    rsp_q.push_back(e);
  endtask

  task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic raise(input int i, input op_t op, input logic [LB-1:0] addr, input int n);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_addr[i]  = addr;
    rem[i]       = n;
  endtask

  // One clock: snapshot outputs at negedge, then retire accepted requests after posedge.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clock);
    s_nx_valid  = nx_valid;
    s_nx_op     = nx_op;
    s_nx_addr   = nx_addr;
    s_rsp_valid = rsp_valid;
    s_rsp_error = rsp_error;
    s_req_ready = req_ready;
    acc         = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        if (rem[i] > 1) rem[i] = rem[i] - 1;
        else begin
          rem[i]       = 0;
          req_valid[i] = 1'b0;
          req_op[i]    = NOP;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on nx handshake and rsp_valid, then drains spot checks.
  initial begin
    nxe_t            en;
    rsp_t            er;
    chk_t            c;
    logic [NREQ-1:0] oh;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (nx_valid && nx_ready) begin
          if (nx_q.size() == 0) cmp("nx_unexpected", 64'(nx_addr), 64'h0);
          else begin
            en = nx_q.pop_front();
            cmp("nx_op", 64'(nx_op), 64'(en.op));
            cmp("nx_addr", 64'(nx_addr), 64'(en.addr));
          end
        end
        if (rsp_valid != '0) begin
          if (rsp_q.size() == 0) cmp("rsp_unexpected", 64'(rsp_valid), 64'h0);
          else begin
            er = rsp_q.pop_front();
            oh = '0;
            oh[er.id] = 1'b1;
            cmp("rsp_valid", 64'(rsp_valid), 64'(oh));
            cmp("rsp_error", 64'(rsp_error), 64'(er.err));
          end
        end
      end
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        cmp(c.name, c.act, c.exp);
      end
      if (end_flag) begin
        cmp("nx_queue_left", 64'(nx_q.size()), 64'h0);
        cmp("rsp_queue_left", 64'(rsp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Absolute time bound in case the run wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int stable;
    int lat;
    stable    = 0;
    lat       = 999;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i]   = NOP;
      req_addr[i] = '0;
      rem[i]      = 0;
    end
    nx_ready = 1'b0;
    nx_done  = 1'b0;
    reset    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state.
    step();
    post("rst_nx_valid",  64'(s_nx_valid),  64'h0);
    post("rst_nx_op",     64'(s_nx_op),     64'(NOP));
    post("rst_nx_addr",   64'(s_nx_addr),   64'h0);
    post("rst_rsp_valid", 64'(s_rsp_valid), 64'h0);
    post("rst_req_ready", 64'(s_req_ready), 64'h0);
    post("rst_cnt0",      64'(grant_cnt[0]), 64'h0);
    post("rst_cnt1",      64'(grant_cnt[1]), 64'h0);

    // Both READ with immediate ready/done: req0 then req1.
    nx_ready = 1'b1;
    nx_done  = 1'b1;
    exp_nx(READ, 26'h11);
    exp_nx(READ, 26'h22);
    exp_rsp(0, 1'b0);
    exp_rsp(1, 1'b0);
    raise(0, READ, 26'h11, 1);
    raise(1, READ, 26'h22, 1);
    repeat (10) step();
    post("t1_cnt0", 64'(grant_cnt[0]), 64'd1);
    post("t1_cnt1", 64'(grant_cnt[1]), 64'd1);

    // Back-pressure: nx_ready low for 5 cycles, nx_valid/addr must hold.
    nx_ready = 1'b0;
    nx_done  = 1'b0;
    exp_nx(READ, 26'h0000040);
    exp_rsp(0, 1'b0);
    raise(0, READ, 26'h0000040, 1);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      if (s_nx_valid && (s_nx_op == READ) && (s_nx_addr == 26'h40)) stable++;
    end
    post("t2_hold_cycles", 64'(stable), 64'd5);
    nx_ready = 1'b1;
    step();
    nx_ready = 1'b0;
    step();
    post("t2_wait_nx_valid", 64'(s_nx_valid), 64'h0);
    nx_done = 1'b1;
    step();
    nx_done = 1'b0;
    step();
    post("t2_rsp_seen", 64'(s_rsp_valid), 64'h1);
    post("t2_cnt0", 64'(grant_cnt[0]), 64'd2);

    // Timeout: rr_ptr is 1, req1 WRITE, nx_done never arrives.
    nx_ready = 1'b1;
    exp_nx(WRITE, 26'h123);
    exp_rsp(1, 1'b1);
    raise(1, WRITE, 26'h123, 1);
    step();
    step();
    nx_ready = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (s_rsp_valid != '0) begin
        lat = k - 1;
        break;
      end
    end
    post("t3_timeout_latency", 64'(lat), 64'(TO + 1));
    post("t3_cnt1", 64'(grant_cnt[1]), 64'd2);

    // RESET op beats READ even though rr_ptr points at req0.
    nx_ready = 1'b1;
    nx_done  = 1'b1;
    exp_nx(RESET, 26'h60);
    exp_nx(READ, 26'h50);
    exp_rsp(1, 1'b0);
    exp_rsp(0, 1'b0);
    raise(0, READ, 26'h50, 1);
    raise(1, RESET, 26'h60, 1);
    repeat (10) step();
    post("t4_cnt0", 64'(grant_cnt[0]), 64'd3);
    post("t4_cnt1", 64'(grant_cnt[1]), 64'd3);

    // Reset while in WAIT: silent abort, everything back to zero.
    nx_ready = 1'b1;
    nx_done  = 1'b0;
    exp_nx(READ, 26'h70);
    raise(0, READ, 26'h70, 1);
    step();
    step();
    nx_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    post("t5_nx_valid",  64'(s_nx_valid),  64'h0);
    post("t5_nx_op",     64'(s_nx_op),     64'(NOP));
    post("t5_nx_addr",   64'(s_nx_addr),   64'h0);
    post("t5_rsp_valid", 64'(s_rsp_valid), 64'h0);
    post("t5_rsp_error", 64'(s_rsp_error), 64'h0);
    post("t5_cnt0",      64'(grant_cnt[0]), 64'h0);
    post("t5_cnt1",      64'(grant_cnt[1]), 64'h0);
    repeat (5) step();

    // 100 back-to-back transactions: strict alternation starting at req0.
    nx_ready = 1'b1;
    nx_done  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      exp_nx(READ, (k % 2 == 1) ? 26'h201 : 26'h200);
      exp_rsp(k % 2, 1'b0);
    end
    raise(0, READ, 26'h200, 50);
    raise(1, READ, 26'h201, 50);
    repeat (320) step();
    post("t6_cnt0", 64'(grant_cnt[0]), 64'd50);
    post("t6_cnt1", 64'(grant_cnt[1]), 64'd50);
    post("t6_req_valid_idle", 64'(req_valid), 64'h0);

    end_flag = 1'b1;
  end

endmodule
